game_flow_ctrl: RTL and testbench

- Top-level game sequencer for the stickman runner.
- Owns the game state machine and drives the 5-bit one-hot `status` bus consumed by the colour mapper: {selecting, waiting, playing, win, lose}.
- Also handles level selection, coin counting and win/lose detection.
- Issues a one-cycle `game_init` pulse that re-initialises stickman, coin and ground logic at the start of each round.

---
 rtl/game_pkg.sv | 32 +++
 rtl/key_edge_detect.sv | 21 ++
 rtl/game_flow_ctrl.sv | 143 ++++++++++++++
 tb/tb_game_flow_ctrl.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared game state encoding and status bus constants
package game_pkg;

  typedef enum logic [2:0] {
    S_WAIT    = 3'd0,
    S_SELECT  = 3'd1,
    S_PREWAIT = 3'd2,
    S_PLAY    = 3'd3,
    S_WIN     = 3'd4,
    S_LOSE    = 3'd5
  } state_t;

  localparam logic [4:0] STAT_SELECT = 5'b10000;
  localparam logic [4:0] STAT_WAIT   = 5'b01000;
  localparam logic [4:0] STAT_PLAY   = 5'b00100;
  localparam logic [4:0] STAT_WIN    = 5'b00010;
  localparam logic [4:0] STAT_LOSE   = 5'b00001;

  // Status code for a state; anything unrecognised shows the cover screen.
  function automatic logic [4:0] state_to_status(input state_t s);
    case (s)
      S_SELECT:  state_to_status = STAT_SELECT;
      S_PREWAIT: state_to_status = STAT_WAIT;
      S_WAIT:    state_to_status = STAT_WAIT;
      S_PLAY:    state_to_status = STAT_PLAY;
      S_WIN:     state_to_status = STAT_WIN;
      S_LOSE:    state_to_status = STAT_LOSE;
      default:   state_to_status = STAT_WAIT;
    endcase
  endfunction

endpackage

// File: rtl/key_edge_detect.sv
// rtl/key_edge_detect.sv - per-bit rising-edge detector for held key levels
module key_edge_detect #(
  parameter int W = 3
) (
  input  logic         Clk,
  input  logic         Reset_n,
  input  logic [W-1:0] i_key,
  output logic [W-1:0] o_press
);

  logic [W-1:0] r_prev;

  // Remember last cycle's key levels so a held key yields only one press.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) r_prev <= '0;
    else          r_prev <= i_key;
  end

  assign o_press = i_key & ~r_prev;

endmodule

// File: rtl/game_flow_ctrl.sv
// rtl/game_flow_ctrl.sv - stickman runner game sequencer: states, levels, coins, win/lose
module game_flow_ctrl
  import game_pkg::*;
#(
  parameter int NUM_LEVELS      = 3,
  parameter int WIN_COINS       = 20,
  parameter int PREWAIT_FRAMES  = 120,
  parameter int END_HOLD_FRAMES = 60
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       frame_tick,
  input  logic       key_start,
  input  logic       key_up,
  input  logic       key_down,
  input  logic       coin_hit,
  input  logic       collision,
  output logic [4:0] status,
  output logic [1:0] level,
  output logic [7:0] coin_cnt,
  output logic       game_init
);

  localparam int MAX_FRAMES = (PREWAIT_FRAMES > END_HOLD_FRAMES) ? PREWAIT_FRAMES : END_HOLD_FRAMES;
  localparam int TW         = $clog2(MAX_FRAMES + 1);

  localparam logic [TW-1:0] PRE_LAST  = TW'(PREWAIT_FRAMES - 1);
  localparam logic [TW-1:0] HOLD_DONE = TW'(END_HOLD_FRAMES);
  localparam logic [1:0]    LVL_MAX   = 2'(NUM_LEVELS - 1);
  localparam logic [7:0]    WIN_LAST  = 8'(WIN_COINS - 1);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [TW-1:0] r_timer;
  logic [1:0]    r_level;
  logic [7:0]    r_coin_cnt;
  logic [4:0]    r_status;
  logic          r_game_init;
  logic [4:0]    w_status_nxt;
  logic          w_game_init_nxt;
  logic [2:0]    w_press;
  logic          w_start_p;
  logic          w_up_p;
  logic          w_down_p;

  key_edge_detect #(.W(3)) u_keys (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .i_key   ({key_down, key_up, key_start}),
    .o_press (w_press)
  );

  assign w_start_p = w_press[0];
  assign w_up_p    = w_press[1];
  assign w_down_p  = w_press[2];

  // State register; reset lands on the cover screen.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) r_state <= S_WAIT;
    else          r_state <= w_state_nxt;
  end

  // Next-state decision; collision outranks a winning coin, unknown codes recover to WAIT.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_WAIT:    if (w_start_p) w_state_nxt = S_SELECT;
      S_SELECT:  if (w_start_p) w_state_nxt = S_PREWAIT;
      S_PREWAIT: if (frame_tick && (r_timer == PRE_LAST)) w_state_nxt = S_PLAY;
      S_PLAY: begin
        if (collision)                                   w_state_nxt = S_LOSE;
        else if (coin_hit && (r_coin_cnt == WIN_LAST))   w_state_nxt = S_WIN;
      end
      S_WIN, S_LOSE: if (w_start_p && (r_timer == HOLD_DONE)) w_state_nxt = S_SELECT;
      default:   w_state_nxt = S_WAIT;
    endcase
  end

  // Output decode from the upcoming state so the registered outputs track the state register.
  always_comb begin
    w_status_nxt    = state_to_status(w_state_nxt);
    w_game_init_nxt = (r_state == S_PREWAIT) && (w_state_nxt == S_PLAY);
  end

  // Registered status bus and one-cycle round-start pulse.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_status    <= STAT_WAIT;
      r_game_init <= 1'b0;
    end else begin
      r_status    <= w_status_nxt;
      r_game_init <= w_game_init_nxt;
    end
  end

  // Frame timer: counts the cover delay and the end-screen hold, zero everywhere else.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_timer <= '0;
    end else begin
      case (r_state)
        S_PREWAIT: begin
          if (w_state_nxt != S_PREWAIT) r_timer <= '0;
          else if (frame_tick)          r_timer <= r_timer + TW'(1);
        end
        S_WIN, S_LOSE: begin
          if (w_state_nxt == S_SELECT)                  r_timer <= '0;
          else if (frame_tick && (r_timer != HOLD_DONE)) r_timer <= r_timer + TW'(1);
        end
        default: r_timer <= '0;
      endcase
    end
  end

  // Level selection wraps both ways; start or a simultaneous up+down leaves it alone.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_level <= 2'd0;
    end else if ((r_state == S_SELECT) && !w_start_p) begin
      if (w_up_p && !w_down_p)
        r_level <= (r_level == LVL_MAX) ? 2'd0 : r_level + 2'd1;
      else if (w_down_p && !w_up_p)
        r_level <= (r_level == 2'd0) ? LVL_MAX : r_level - 2'd1;
    end
  end

  // Coin counter clears at round start and saturates; it keeps its value on the end screens.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_coin_cnt <= 8'd0;
    end else if (w_game_init_nxt) begin
      r_coin_cnt <= 8'd0;
    end else if ((r_state == S_PLAY) && coin_hit && (r_coin_cnt != 8'hFF)) begin
      r_coin_cnt <= r_coin_cnt + 8'd1;
    end
  end

  assign status    = r_status;
  assign level     = r_level;
  assign coin_cnt  = r_coin_cnt;
  assign game_init = r_game_init;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// tb/tb_game_flow_ctrl.sv - directed self-checking bench for game_flow_ctrl
module tb_game_flow_ctrl;

  logic       Clk = 1'b0;
  logic       Reset_n;
  logic       frame_tick;
  logic       key_start;
  logic       key_up;
  logic       key_down;
  logic       coin_hit;
  logic       collision;
  logic [4:0] status;
  logic [1:0] level;
  logic [7:0] coin_cnt;
  logic       game_init;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 Clk = ~Clk;

  game_flow_ctrl #(
    .NUM_LEVELS      (3),
    .WIN_COINS       (3),
    .PREWAIT_FRAMES  (4),
    .END_HOLD_FRAMES (2)
  ) dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .frame_tick (frame_tick),
    .key_start  (key_start),
    .key_up     (key_up),
    .key_down   (key_down),
    .coin_hit   (coin_hit),
    .collision  (collision),
    .status     (status),
    .level      (level),
    .coin_cnt   (coin_cnt),
    .game_init  (game_init)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // k: 0 start, 1 up, 2 down, 3 up+down together
  task automatic press(input int k);
    @(negedge Clk);
    key_start = (k == 0);
    key_up    = (k == 1) || (k == 3);
    key_down  = (k == 2) || (k == 3);
    @(negedge Clk);
    key_start = 1'b0;
    key_up    = 1'b0;
    key_down  = 1'b0;
  endtask

  task automatic tick();
    repeat (8) @(negedge Clk);
    @(negedge Clk);
    frame_tick = 1'b1;
    @(negedge Clk);
    frame_tick = 1'b0;
  endtask

  task automatic coin(input logic col);
    @(negedge Clk);
    coin_hit  = 1'b1;
    collision = col;
    @(negedge Clk);
    coin_hit  = 1'b0;
    collision = 1'b0;
  endtask

  // Four frame ticks through PREWAIT, checking the cover screen holds and game_init fires once.
  task automatic run_prewait(input string tag);
    for (int t = 1; t <= 4; t++) begin
      tick();
      if (t < 4) begin
        check_eq({tag, "_wait_status"}, 32'(status), 'b01000);
        check_eq({tag, "_wait_init"}, 32'(game_init), 0);
      end else begin
        check_eq({tag, "_play_status"}, 32'(status), 'b00100);
        check_eq({tag, "_play_init"}, 32'(game_init), 1);
        check_eq({tag, "_play_coin"}, 32'(coin_cnt), 0);
      end
    end
    @(negedge Clk);
    check_eq({tag, "_init_one_cycle"}, 32'(game_init), 0);
  endtask

  initial begin
    int n_gi;
    int n_bad_stat;
    Reset_n = 1'b0; frame_tick = 1'b0; key_start = 1'b0; key_up = 1'b0;
    key_down = 1'b0; coin_hit = 1'b0; collision = 1'b0;
    repeat (3) @(negedge Clk);
    check_eq("rst_status", 32'(status), 'b01000);
    check_eq("rst_level", 32'(level), 0);
    check_eq("rst_coin", 32'(coin_cnt), 0);
    check_eq("rst_init", 32'(game_init), 0);
    @(negedge Clk);
    Reset_n = 1'b1;
    repeat (2) @(negedge Clk);

    press(0);
    check_eq("wait_to_select", 32'(status), 'b10000);
    check_eq("select_level0", 32'(level), 0);

    press(1); check_eq("up1", 32'(level), 1);
    press(1); check_eq("up2", 32'(level), 2);
    press(1); check_eq("up_wrap", 32'(level), 0);
    press(2); check_eq("down_wrap", 32'(level), 2);

    @(negedge Clk); key_up = 1'b1;
    repeat (100) @(negedge Clk);
    key_up = 1'b0;
    check_eq("up_held_once", 32'(level), 0);
    press(3); check_eq("up_down_same", 32'(level), 0);
    press(1); check_eq("up_to_1", 32'(level), 1);

    press(0);
    check_eq("select_to_prewait", 32'(status), 'b01000);
    check_eq("start_keeps_level", 32'(level), 1);
    press(1);
    check_eq("prewait_ignores_up", 32'(level), 1);
    run_prewait("r1");

    coin(1'b0); check_eq("r1_coin1", 32'(coin_cnt), 1); check_eq("r1_play1", 32'(status), 'b00100);
    coin(1'b0); check_eq("r1_coin2", 32'(coin_cnt), 2);
    coin(1'b0); check_eq("r1_coin3", 32'(coin_cnt), 3); check_eq("r1_win", 32'(status), 'b00010);

    press(0); check_eq("win_early_start", 32'(status), 'b00010);
    tick(); tick(); tick();
    press(0);
    check_eq("win_to_select", 32'(status), 'b10000);
    check_eq("win_level_kept", 32'(level), 1);
    check_eq("win_coin_held", 32'(coin_cnt), 3);

    press(0);
    run_prewait("r2");
    coin(1'b0); check_eq("r2_coin1", 32'(coin_cnt), 1);
    coin(1'b0); check_eq("r2_coin2", 32'(coin_cnt), 2);
    coin(1'b1);
    check_eq("r2_lose", 32'(status), 'b00001);
    check_eq("r2_lose_coin", 32'(coin_cnt), 3);
    tick();
    press(0); check_eq("lose_one_tick", 32'(status), 'b00001);
    tick();
    press(0);
    check_eq("lose_to_select", 32'(status), 'b10000);
    check_eq("lose_level_kept", 32'(level), 1);

    press(0);
    check_eq("r3_prewait", 32'(status), 'b01000);
    tick(); tick();
    @(posedge Clk);
    #3 Reset_n = 1'b0;
    #1;
    check_eq("async_rst_status", 32'(status), 'b01000);
    check_eq("async_rst_level", 32'(level), 0);
    check_eq("async_rst_init", 32'(game_init), 0);
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;
    n_gi = 0;
    n_bad_stat = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge Clk);
      frame_tick = (i % 10 == 0);
      if (game_init) n_gi++;
      if (status != 5'b01000) n_bad_stat++;
    end
    frame_tick = 1'b0;
    check_eq("no_init_after_rst", 32'(n_gi), 0);
    check_eq("stay_wait_after_rst", 32'(n_bad_stat), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
